calc_sequencer: RTL and testbench

//  Command-driven sequencer for the 4-bit calculator datapath (RegA, RegB, Sel mux, ULA, RegC).

---
 rtl/calc_sequencer_pkg.sv | 40 ++++
 rtl/calc_sequencer_cmd_fifo.sv | 67 ++++++
 rtl/calc_sequencer.sv | 124 ++++++++++++
 tb/tb_calc_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calculator command sequencer: opcodes, RegC control codes,
// FSM states and the command word layout.
package calc_sequencer_pkg;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CMD_W = 7;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LDA     = 3'b001;
  localparam logic [2:0] OP_LDB     = 3'b010;
  localparam logic [2:0] OP_EXEC_AB = 3'b011;
  localparam logic [2:0] OP_EXEC_AC = 3'b100;
  localparam logic [2:0] OP_CLRC    = 3'b101;
  localparam logic [2:0] OP_HALT    = 3'b110;
  localparam logic [2:0] OP_RSV     = 3'b111;

  localparam logic [1:0] RC_HOLD = 2'b00;
  localparam logic [1:0] RC_LOAD = 2'b01;
  localparam logic [1:0] RC_CLR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_DRIVE  = 3'd2,
    S_SETTLE = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] data;
  } cmd_t;

  // Commands that write RegC need one quiet cycle afterwards for the write to land.
  function automatic logic needs_settle(input logic [2:0] op);
    return (op == OP_EXEC_AB) || (op == OP_EXEC_AC) || (op == OP_CLRC);
  endfunction

endpackage

// File: rtl/calc_sequencer_cmd_fifo.sv
// Synchronous command FIFO; the read word is registered on pop so the consumer sees it
// one cycle after requesting it.
module cmd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = rd_data_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/calc_sequencer.sv
// Command sequencer for the 4-bit calculator datapath: pops queued command words and
// replays each as a one-cycle burst of RegA/RegB/mux/ULA/RegC controls.
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int DEPTH = calc_sequencer_pkg::DEPTH,
  parameter int AW    = calc_sequencer_pkg::AW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] dados_out,
  output logic       en_a,
  output logic       en_b,
  output logic       sel,
  output logic [1:0] op,
  output logic [1:0] op_reg,
  output logic       busy,
  output logic       fim,
  output logic       err,
  output logic [2:0] state
);

  state_e           state_q, state_d;
  cmd_t             cur_cmd_q, cur_cmd_d;
  logic             err_q, err_d;
  logic [CMD_W-1:0] fifo_rd_data;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign cmd_ready = ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;
  assign fifo_pop  = (state_q == S_IDLE) & ~fifo_empty;

  cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_cmd_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_data({cmd_op, cmd_data}),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_cmd_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_cmd_q <= cur_cmd_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_cmd_d = cur_cmd_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE:   if (!fifo_empty) state_d = S_DECODE;
      S_DECODE: begin
        cur_cmd_d = cmd_t'(fifo_rd_data);
        state_d   = S_DRIVE;
      end
      S_DRIVE: begin
        if (cur_cmd_q.op == OP_RSV) err_d = 1'b1;
        if (needs_settle(cur_cmd_q.op))   state_d = S_SETTLE;
        else if (cur_cmd_q.op == OP_HALT) state_d = S_HALTED;
        else                              state_d = S_IDLE;
      end
      S_SETTLE: state_d = S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore decode: controls depend only on registered state and the latched command.
  always_comb begin
    dados_out = 4'h0;
    en_a      = 1'b0;
    en_b      = 1'b0;
    sel       = 1'b0;
    op        = 2'b00;
    op_reg    = RC_HOLD;
    if (state_q == S_DRIVE) begin
      case (cur_cmd_q.op)
        OP_LDA: begin
          en_a      = 1'b1;
          dados_out = cur_cmd_q.data;
        end
        OP_LDB: begin
          en_b      = 1'b1;
          dados_out = cur_cmd_q.data;
        end
        OP_EXEC_AB: begin
          op     = cur_cmd_q.data[1:0];
          op_reg = RC_LOAD;
        end
        OP_EXEC_AC: begin
          sel    = 1'b1;
          op     = cur_cmd_q.data[1:0];
          op_reg = RC_LOAD;
        end
        OP_CLRC: op_reg = RC_CLR;
        default: ;
      endcase
    end
  end

  assign busy  = (state_q != S_IDLE) | ~fifo_empty;
  assign fim   = (state_q == S_HALTED);
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: expected DRIVE bursts are queued as commands are
// pushed and compared when the sequencer shows DRIVE; a small datapath model tracks RegC.
module tb_calc_sequencer;
  import calc_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'b000;
  logic [3:0] cmd_data = 4'h0;
  logic       cmd_ready, en_a, en_b, sel, busy, fim, err;
  logic [3:0] dados_out;
  logic [1:0] op, op_reg;
  logic [2:0] state;

  calc_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .dados_out(dados_out),
    .en_a     (en_a),
    .en_b     (en_b),
    .sel      (sel),
    .op       (op),
    .op_reg   (op_reg),
    .busy     (busy),
    .fim      (fim),
    .err      (err),
    .state    (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [10:0] ctrl;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int  model_free = 0;
  bit  model_halted = 1'b0;
  int  last_push_cyc = 0;
  logic [3:0] reg_a = 4'h0, reg_b = 4'h0, reg_c = 4'h0;

  logic [10:0] ctrl_obs;
  assign ctrl_obs = {dados_out, en_a, en_b, sel, op, op_reg};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Controls each opcode should assert during its DRIVE cycle.
  function automatic logic [10:0] expCtrl(input logic [2:0] o, input logic [3:0] d);
    case (o)
      3'b001:  return {d, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
      3'b010:  return {d, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
      3'b011:  return {4'h0, 1'b0, 1'b0, 1'b0, d[1:0], 2'b01};
      3'b100:  return {4'h0, 1'b0, 1'b0, 1'b1, d[1:0], 2'b01};
      3'b101:  return {4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10};
      default: return 11'h000;
    endcase
  endfunction

  function automatic logic [3:0] ula(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
    case (f)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // Reference datapath driven by the sequencer outputs.
  always @(posedge clk) begin
    if (rst) begin
      reg_a <= 4'h0;
      reg_b <= 4'h0;
      reg_c <= 4'h0;
    end else begin
      if (en_a) reg_a <= dados_out;
      if (en_b) reg_b <= dados_out;
      if (op_reg == 2'b01) reg_c <= ula(reg_a, sel ? reg_c : reg_b, op);
      else if (op_reg == 2'b10) reg_c <= 4'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (state == 3'd2) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_drive_queue", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("drive_ctrl", ctrl_obs, e.ctrl);
          checkOutput("drive_cycle", cyc, e.cyc);
        end
      end else begin
        checkOutput("quiet_ctrl", ctrl_obs, 11'h000);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] o, input logic [3:0] d);
    int waited = 0;
    int pop_cyc, drv_cyc;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = o;
    cmd_data  = d;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("push_timeout", cmd_ready, 1'b1);
    end else begin
      last_push_cyc = cyc;
      if (!model_halted) begin
        pop_cyc    = (cyc + 1 > model_free) ? cyc + 1 : model_free;
        drv_cyc    = pop_cyc + 2;
        e.ctrl     = expCtrl(o, d);
        e.cyc      = drv_cyc;
        sb.push_back(e);
        model_free = drv_cyc + ((o == 3'b011 || o == 3'b100 || o == 3'b101) ? 2 : 1);
        if (o == 3'b110) model_halted = 1'b1;
      end
    end
  endtask

  task automatic idleInputs();
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = 4'h0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    model_free   = 0;
    model_halted = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || state != 3'd0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", sb.size(), 0);
    checkOutput("drain_state", state, 3'd0);
  endtask

  task automatic waitFim();
    int n = 0;
    while (!fim && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fim_rise", fim, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int accepted;
    int n;

    doReset();
    checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_fim", fim, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_state", state, 3'd0);
    checkOutput("rst_ctrl", ctrl_obs, 11'h000);

    applyStimulus(OP_LDA, 4'h5);
    idleInputs();
    n = 0;
    while (cyc < last_push_cyc + 4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lda_state_after", state, 3'd0);
    checkOutput("lda_reg_a", reg_a, 4'h5);

    applyStimulus(OP_LDA, 4'h3);
    applyStimulus(OP_LDB, 4'h2);
    applyStimulus(OP_EXEC_AB, 4'h0);
    idleInputs();
    drain();
    checkOutput("exec_ab_reg_c", reg_c, 4'h5);

    applyStimulus(OP_EXEC_AC, 4'h0);
    applyStimulus(OP_EXEC_AC, 4'h0);
    idleInputs();
    drain();
    checkOutput("exec_ac_reg_a", reg_a, 4'h3);
    checkOutput("exec_ac_reg_c", reg_c, 4'hB);

    applyStimulus(OP_HALT, 4'h0);
    idleInputs();
    waitFim();
    checkOutput("halt_state", state, 3'd4);
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_LDA;
      cmd_data  = 4'(i + 1);
      if (cmd_ready) accepted++;
    end
    idleInputs();
    checkOutput("halt_accepted", accepted, 4);
    checkOutput("halt_full_ready", cmd_ready, 1'b0);
    checkOutput("halt_busy", busy, 1'b1);

    doReset();
    checkOutput("rst2_fim", fim, 1'b0);
    checkOutput("rst2_busy", busy, 1'b0);
    checkOutput("rst2_cmd_ready", cmd_ready, 1'b1);

    applyStimulus(OP_RSV, 4'hF);
    applyStimulus(OP_HALT, 4'h0);
    applyStimulus(OP_LDA, 4'h9);
    idleInputs();
    waitFim();
    checkOutput("rsv_err", err, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("rsv_err_sticky", err, 1'b1);
    checkOutput("halt_fim_held", fim, 1'b1);
    checkOutput("queued_busy", busy, 1'b1);
    checkOutput("queued_reg_a", reg_a, 4'h0);
    checkOutput("pending_drives", sb.size(), 0);

    doReset();
    checkOutput("rst3_fim", fim, 1'b0);
    checkOutput("rst3_err", err, 1'b0);
    checkOutput("rst3_busy", busy, 1'b0);
    checkOutput("rst3_state", state, 3'd0);
    checkOutput("rst3_cmd_ready", cmd_ready, 1'b1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
